board_ctl: RTL and testbench

- Playfield responder for the falling-block controller. Takes the active piece (xpos, ypos, block, rot) and returns the four square columns plus a one-step-down collision flag.
- On lock_en it writes the piece into the board, clears full rows and reports the number of cleared lines.
- Provides a registered row-read port for the display renderer.

---
 rtl/board_ctl_if.sv | 44 ++++
 rtl/board_ctl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_board_ctl.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_ctl_if.sv
// board_ctl_if: groups the falling-block controller's connection to the
// playfield responder into one bundle.
//   master modport : the game controller / display side (drives piece, lock,
//                    clear and read-row requests, receives results)
//   slave modport  : board_ctl itself
// Signals:
//   xpos[3:0], ypos[4:0], block[4:0], rot[1:0] : active piece
//   lock_en, clear_board                       : lock request / board wipe
//   rd_row[4:0] -> rd_data[9:0]                : display row read
//   sq_1_col..sq_4_col[3:0], collision         : piece geometry results
//   busy, lines_done, lines_cleared[2:0]       : lock sequence status
//   game_over, score_inc[11:0]                 : game status
interface board_ctl_if;
    logic [3:0]  xpos;
    logic [4:0]  ypos;
    logic [4:0]  block;
    logic [1:0]  rot;
    logic        lock_en;
    logic        clear_board;
    logic [4:0]  rd_row;
    logic [3:0]  sq_1_col;
    logic [3:0]  sq_2_col;
    logic [3:0]  sq_3_col;
    logic [3:0]  sq_4_col;
    logic        collision;
    logic        busy;
    logic        lines_done;
    logic [2:0]  lines_cleared;
    logic        game_over;
    logic [9:0]  rd_data;
    logic [11:0] score_inc;

    modport master (
        output xpos, ypos, block, rot, lock_en, clear_board, rd_row,
        input  sq_1_col, sq_2_col, sq_3_col, sq_4_col, collision, busy,
               lines_done, lines_cleared, game_over, rd_data, score_inc
    );

    modport slave (
        input  xpos, ypos, block, rot, lock_en, clear_board, rd_row,
        output sq_1_col, sq_2_col, sq_3_col, sq_4_col, collision, busy,
               lines_done, lines_cleared, game_over, rd_data, score_inc
    );
endinterface

// File: rtl/board_ctl.sv
// board_ctl: playfield responder for the falling-block controller.
// Computes the four square columns of the active piece and a registered
// "cannot move down" flag, locks pieces into the board on a lock_en rising
// edge, removes full rows, and offers a registered row-read port.
// Ports:
//   pclk        : clock
//   rst         : synchronous active-high reset
//   bus (slave) : board_ctl_if - piece inputs, lock/clear, rd_row in;
//                 square columns, collision, busy, lines_done,
//                 lines_cleared, game_over, rd_data, score_inc out
// Parameters: ROWS (<= 32, row 0 = top), COLS (fixed at 10).
// Build option: define BOARD_SCORE_EN to register the classic line-clear
// score in score_inc; otherwise score_inc is tied to 0.
module board_ctl #(
    parameter int unsigned ROWS = 22,
    parameter int unsigned COLS = 10
) (
    input  logic       pclk,
    input  logic       rst,
    board_ctl_if.slave bus
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SCAN,
        S_SHIFT,
        S_DONE
    } state_t;

    // Rot-0 offsets, one byte per square {dx[3:0], dy[3:0]}, square 0 in
    // the low byte; both nibbles are two's complement.
    function automatic logic [7:0] shape_off(input logic [2:0] kind,
                                             input logic [1:0] idx);
        logic [31:0] w;
        case (kind)
            3'd0:    w = 32'h20_10_00_F0;  // I
            3'd1:    w = 32'h11_01_10_00;  // O
            3'd2:    w = 32'h01_10_00_F0;  // T
            3'd3:    w = 32'h01_F1_10_00;  // S
            3'd4:    w = 32'h11_01_00_F0;  // Z
            3'd5:    w = 32'h11_10_00_F0;  // J
            default: w = 32'hF1_10_00_F0;  // L
        endcase
        return w[{idx, 3'b000} +: 8];
    endfunction

    // Returns {col[5:0], row[5:0]} for one square, both two's complement.
    function automatic logic [11:0] sq_pos(input logic [3:0] x,
                                           input logic [4:0] y,
                                           input logic [4:0] blk,
                                           input logic [1:0] rt,
                                           input logic [1:0] idx);
        logic [7:0] off;
        logic [3:0] dx, dy, rx, ry;
        logic [1:0] r_eff;
        logic [5:0] c, r;
        off   = shape_off(blk[2:0], idx);
        dx    = off[7:4];
        dy    = off[3:0];
        r_eff = (blk == 5'b10001) ? 2'd0 : rt;
        // Closed form of applying (dx,dy) -> (-dy,dx) r_eff times.
        case (r_eff)
            2'd0:    begin rx = dx;      ry = dy;      end
            2'd1:    begin rx = 4'd0-dy; ry = dx;      end
            2'd2:    begin rx = 4'd0-dx; ry = 4'd0-dy; end
            default: begin rx = dy;      ry = 4'd0-dx; end
        endcase
        c = {2'b00, x} + {{2{rx[3]}}, rx};
        r = {1'b0, y}  + {{2{ry[3]}}, ry};
        return {c, r};
    endfunction

    // Board storage and lock-sequence state.
    logic [COLS-1:0] board_q [ROWS];
    logic [COLS-1:0] board_d [ROWS];
    state_t          state_q, state_d;
    logic [RW-1:0]   r_q, r_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            go_q, go_d;
    logic [2:0]      lines_q, lines_d;
    logic            lock_en_q;
    logic [RW-1:0]   lk_row_q [4];
    logic [RW-1:0]   lk_row_d [4];
    logic [3:0]      lk_col_q [4];
    logic [3:0]      lk_col_d [4];
    logic            lk_wr_q  [4];
    logic            lk_wr_d  [4];
    logic            enter_done;
    logic            lock_rise;

    // Piece geometry and registered outputs.
    logic            blk_ok;
    logic [5:0]      sq_col   [4];
    logic [5:0]      sq_row   [4];
    logic [5:0]      sq_below [4];
    logic            sq_in    [4];
    logic            sq_floor [4];
    logic            sq_wr    [4];
    logic            sq_hit   [4];
    logic [3:0]      sq_col_q [4];
    logic [3:0]      sq_col_d [4];
    logic            collision_q, collision_d;
    logic [COLS-1:0] rd_data_q, rd_data_d;

    assign lock_rise = bus.lock_en && !lock_en_q;

    always_comb begin
        blk_ok      = (bus.block >= 5'b10000) && (bus.block <= 5'b10110);
        collision_d = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            {sq_col[i], sq_row[i]} = sq_pos(bus.xpos, bus.ypos, bus.block,
                                            bus.rot, 2'(i));
            // Squares left/right of the board or above row 0 never collide
            // and are never written.
            sq_in[i]    = blk_ok && !sq_col[i][5] && !sq_row[i][5] &&
                          (sq_col[i][4:0] < 5'(COLS));
            sq_below[i] = {1'b0, sq_row[i][4:0]} + 6'd1;
            sq_floor[i] = (32'(sq_below[i]) >= ROWS);
            sq_wr[i]    = sq_in[i] && (32'(sq_row[i][4:0]) < ROWS);
            sq_hit[i]   = sq_in[i] &&
                          (sq_floor[i] ||
                           board_q[RW'(sq_below[i])][sq_col[i][3:0]]);
            sq_col_d[i] = blk_ok ? sq_col[i][3:0] : 4'h0;
            collision_d = collision_d | sq_hit[i];
        end
        rd_data_d = (32'(bus.rd_row) < ROWS) ? board_q[RW'(bus.rd_row)] : '0;
    end

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        go_d       = go_q;
        lines_d    = lines_q;
        lk_row_d   = lk_row_q;
        lk_col_d   = lk_col_q;
        lk_wr_d    = lk_wr_q;
        enter_done = 1'b0;
        if (bus.clear_board) begin
            state_d = S_IDLE;
            board_d = '{default: '0};
            go_d    = 1'b0;
            lines_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lock_rise) begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            lk_row_d[i] = RW'(sq_row[i][4:0]);
                            lk_col_d[i] = sq_col[i][3:0];
                            lk_wr_d[i]  = sq_wr[i];
                        end
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (lk_wr_q[i]) begin
                            board_d[lk_row_q[i]][lk_col_q[i]] = 1'b1;
                            if (lk_row_q[i] == '0) go_d = 1'b1;
                        end
                    end
                    r_d     = RW'(ROWS - 1);
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end
                S_SCAN: begin
                    if (&board_q[r_q]) begin
                        state_d = S_SHIFT;
                    end else if (r_q == '0) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                        lines_d    = cnt_q;
                    end else begin
                        r_d = r_q - 1'b1;
                    end
                end
                S_SHIFT: begin
                    // Rescan the same row afterwards: the row dropped into
                    // it may itself be full.
                    for (int unsigned i = 1; i < ROWS; i++) begin
                        if (i <= 32'(r_q)) board_d[RW'(i)] = board_q[RW'(i - 1)];
                    end
                    board_d[0] = '0;
                    cnt_d      = (cnt_q == 3'd4) ? cnt_q : cnt_q + 3'd1;
                    state_d    = S_SCAN;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            board_q     <= '{default: '0};
            r_q         <= '0;
            cnt_q       <= '0;
            go_q        <= 1'b0;
            lines_q     <= '0;
            lock_en_q   <= 1'b0;
            lk_row_q    <= '{default: '0};
            lk_col_q    <= '{default: '0};
            lk_wr_q     <= '{default: 1'b0};
            sq_col_q    <= '{default: '0};
            collision_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            go_q        <= go_d;
            lines_q     <= lines_d;
            lock_en_q   <= bus.lock_en;
            lk_row_q    <= lk_row_d;
            lk_col_q    <= lk_col_d;
            lk_wr_q     <= lk_wr_d;
            sq_col_q    <= sq_col_d;
            collision_q <= collision_d;
            rd_data_q   <= rd_data_d;
        end
    end

`ifdef BOARD_SCORE_EN
    logic [11:0] score_q, score_d;

    always_comb begin
        score_d = score_q;
        if (bus.clear_board) begin
            score_d = '0;
        end else if (enter_done) begin
            case (cnt_q)
                3'd1:    score_d = 12'd40;
                3'd2:    score_d = 12'd100;
                3'd3:    score_d = 12'd300;
                3'd4:    score_d = 12'd1200;
                default: score_d = 12'd0;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) score_q <= '0;
        else     score_q <= score_d;
    end

    assign bus.score_inc = score_q;
`else
    assign bus.score_inc = '0;
`endif

    assign bus.sq_1_col      = sq_col_q[0];
    assign bus.sq_2_col      = sq_col_q[1];
    assign bus.sq_3_col      = sq_col_q[2];
    assign bus.sq_4_col      = sq_col_q[3];
    assign bus.collision     = collision_q;
    assign bus.busy          = (state_q == S_WRITE) || (state_q == S_SCAN) ||
                               (state_q == S_SHIFT);
    assign bus.lines_done    = (state_q == S_DONE);
    assign bus.lines_cleared = lines_q;
    assign bus.game_over     = go_q;
    assign bus.rd_data       = rd_data_q;

endmodule

// File: tb/tb_board_ctl.sv
// tb_board_ctl: self-checking bench for board_ctl. A behavioural playfield
// model predicts geometry, collision, lock results and row contents; the
// predictions are queued when stimulus is applied and compared when the
// DUT result becomes visible.
module tb_board_ctl;
    localparam int ROWS = 22;

    logic pclk = 1'b0;
    logic rst;

    board_ctl_if bus ();

    board_ctl #(.ROWS(ROWS), .COLS(10)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    // Reference playfield
    logic [9:0] mb [ROWS];
    int         m_lines;
    int         m_score;
    bit         m_go;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underrun", 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic void piece_sq(input int blk, input int rot, input int x,
                                     input int y, input int idx,
                                     output int c, output int r, output bit ok);
        int tdx[4];
        int tdy[4];
        int dx, dy, t;
        ok = 1'b1;
        case (blk)
            16: begin tdx = '{-1, 0, 1, 2}; tdy = '{0, 0, 0, 0}; end
            17: begin tdx = '{0, 1, 0, 1};  tdy = '{0, 0, 1, 1}; end
            18: begin tdx = '{-1, 0, 1, 0}; tdy = '{0, 0, 0, 1}; end
            19: begin tdx = '{0, 1, -1, 0}; tdy = '{0, 0, 1, 1}; end
            20: begin tdx = '{-1, 0, 0, 1}; tdy = '{0, 0, 1, 1}; end
            21: begin tdx = '{-1, 0, 1, 1}; tdy = '{0, 0, 0, 1}; end
            22: begin tdx = '{-1, 0, 1, -1}; tdy = '{0, 0, 0, 1}; end
            default: begin tdx = '{0, 0, 0, 0}; tdy = '{0, 0, 0, 0}; ok = 1'b0; end
        endcase
        dx = tdx[idx];
        dy = tdy[idx];
        if (blk != 17) begin
            for (int k = 0; k < rot; k++) begin
                t  = dx;
                dx = -dy;
                dy = t;
            end
        end
        c = x + dx;
        r = y + dy;
    endfunction

    function automatic bit model_collision(input int blk, input int rot,
                                           input int x, input int y);
        int c, r;
        bit ok, hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            piece_sq(blk, rot, x, y, i, c, r, ok);
            if (ok && r >= 0 && c >= 0 && c < 10)
                if (r + 1 >= ROWS || mb[r + 1][c]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic void model_lock(input int blk, input int rot,
                                       input int x, input int y);
        int c, r, dst, full_n;
        bit ok;
        logic [9:0] nb [ROWS];
        for (int i = 0; i < 4; i++) begin
            piece_sq(blk, rot, x, y, i, c, r, ok);
            if (ok && r >= 0 && r < ROWS && c >= 0 && c < 10) begin
                mb[r][c] = 1'b1;
                if (r == 0) m_go = 1'b1;
            end
        end
        // Compact surviving rows towards the bottom.
        for (int i = 0; i < ROWS; i++) nb[i] = '0;
        dst    = ROWS - 1;
        full_n = 0;
        for (int src = ROWS - 1; src >= 0; src--) begin
            if (mb[src] == 10'h3FF) begin
                full_n++;
            end else begin
                nb[dst] = mb[src];
                dst--;
            end
        end
        for (int i = 0; i < ROWS; i++) mb[i] = nb[i];
        m_lines = (full_n > 4) ? 4 : full_n;
        case (m_lines)
            1:       m_score = 40;
            2:       m_score = 100;
            3:       m_score = 300;
            4:       m_score = 1200;
            default: m_score = 0;
        endcase
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < ROWS; i++) mb[i] = '0;
        m_go    = 1'b0;
        m_lines = 0;
        m_score = 0;
    endfunction

    function automatic int exp_score();
`ifdef BOARD_SCORE_EN
        return m_score;
`else
        return 0;
`endif
    endfunction

    task automatic set_piece(input int blk, input int rot, input int x, input int y);
        bus.block = 5'(blk);
        bus.rot   = 2'(rot);
        bus.xpos  = 4'(x);
        bus.ypos  = 5'(y);
    endtask

    task automatic geo(input int blk, input int rot, input int x, input int y);
        int c, r;
        bit ok;
        set_piece(blk, rot, x, y);
        for (int i = 0; i < 4; i++) begin
            piece_sq(blk, rot, x, y, i, c, r, ok);
            if (ok) sb_push($sformatf("sq%0d_col b%0d r%0d", i + 1, blk, rot), 32'(c & 15));
        end
        piece_sq(blk, rot, x, y, 0, c, r, ok);
        sb_push($sformatf("collision b%0d x%0d y%0d", blk, x, y),
                32'(model_collision(blk, rot, x, y)));
        tick();
        if (ok) begin
            sb_pop(32'(bus.sq_1_col));
            sb_pop(32'(bus.sq_2_col));
            sb_pop(32'(bus.sq_3_col));
            sb_pop(32'(bus.sq_4_col));
        end
        sb_pop(32'(bus.collision));
    endtask

    task automatic do_lock(input int blk, input int rot, input int x, input int y,
                           output int busy_n);
        bit seen;
        set_piece(blk, rot, x, y);
        model_lock(blk, rot, x, y);
        sb_push("lines_cleared", 32'(m_lines));
        sb_push("game_over", 32'(m_go));
        sb_push("score_inc", 32'(exp_score()));
        bus.lock_en = 1'b1;
        tick();
        bus.lock_en = 1'b0;
        busy_n = 0;
        seen   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.lines_done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_n++;
            tick();
        end
        check("lock_done_seen", 32'(seen), 1);
        sb_pop(32'(bus.lines_cleared));
        sb_pop(32'(bus.game_over));
        sb_pop(32'(bus.score_inc));
        tick();
        check("done_pulse_width", 32'(bus.lines_done), 0);
        check("busy_after_done", 32'(bus.busy), 0);
    endtask

    task automatic dump_rows();
        for (int r = 0; r < ROWS; r++) begin
            bus.rd_row = 5'(r);
            sb_push($sformatf("row%0d", r), 32'(mb[r]));
            tick();
            sb_pop(32'(bus.rd_data));
        end
    endtask

    task automatic do_clear();
        bus.clear_board = 1'b1;
        tick();
        bus.clear_board = 1'b0;
        model_clear();
        check("clear_busy", 32'(bus.busy), 0);
        check("clear_game_over", 32'(bus.game_over), 0);
        check("clear_lines", 32'(bus.lines_cleared), 0);
        check("clear_score", 32'(bus.score_inc), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, done_n;

        rst             = 1'b1;
        bus.xpos        = '0;
        bus.ypos        = '0;
        bus.block       = '0;
        bus.rot         = '0;
        bus.lock_en     = 1'b0;
        bus.clear_board = 1'b0;
        bus.rd_row      = '0;
        model_clear();
        tick();
        tick();

        check("rst_busy", 32'(bus.busy), 0);
        check("rst_lines_done", 32'(bus.lines_done), 0);
        check("rst_lines_cleared", 32'(bus.lines_cleared), 0);
        check("rst_game_over", 32'(bus.game_over), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_collision", 32'(bus.collision), 0);
        check("rst_sq1", 32'(bus.sq_1_col), 0);
        check("rst_score", 32'(bus.score_inc), 0);
        rst = 1'b0;
        tick();

        // Geometry on an empty board
        geo(18, 0, 5, 19);
        check("t_plan_cols", {bus.sq_1_col, bus.sq_2_col, bus.sq_3_col, bus.sq_4_col},
              32'h4565);
        geo(18, 0, 5, 20);
        geo(16, 1, 9, 19);
        geo(22, 3, 5, 5);
        geo(19, 2, 3, 10);
        geo(20, 1, 6, 12);
        geo(21, 2, 4, 8);
        geo(17, 3, 0, 20);
        geo(16, 0, 0, 5);
        geo(3, 0, 5, 21);

        // Build row 21 = cols 0-5 and 9, then complete it with an I
        do_lock(16, 0, 1, 21, busy_n);
        do_lock(17, 0, 4, 20, busy_n);
        do_lock(16, 1, 9, 19, busy_n);
        geo(18, 0, 5, 18);
        geo(18, 0, 5, 19);
        do_lock(16, 0, 7, 21, busy_n);
        check("busy_len_ge_rows", 32'(busy_n >= ROWS), 1);
        dump_rows();

        // Four-line clear
        do_clear();
        for (int c = 0; c < 9; c++) do_lock(16, 1, c, 19, busy_n);
        do_lock(16, 1, 9, 19, busy_n);
        dump_rows();

        // Top-out, then wipe
        do_lock(17, 0, 4, 0, busy_n);
        do_clear();
        dump_rows();

        // lock_en held high for five cycles triggers one lock
        set_piece(18, 2, 5, 10);
        model_lock(18, 2, 5, 10);
        done_n      = 0;
        bus.lock_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (k == 4) bus.lock_en = 1'b0;
            if (bus.lines_done) done_n++;
        end
        check("hold_single_done", 32'(done_n), 1);
        dump_rows();

        // Wipe in the middle of a scan
        set_piece(16, 0, 1, 21);
        bus.lock_en = 1'b1;
        tick();
        bus.lock_en = 1'b0;
        tick();
        tick();
        tick();
        check("busy_mid_scan", 32'(bus.busy), 1);
        bus.clear_board = 1'b1;
        tick();
        bus.clear_board = 1'b0;
        model_clear();
        check("busy_after_abort", 32'(bus.busy), 0);
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.lines_done) done_n++;
            tick();
        end
        check("abort_no_done", 32'(done_n), 0);
        dump_rows();

        // Read port: out-of-range row and one-cycle latency
        bus.rd_row = 5'd25;
        tick();
        check("rd_row_25", 32'(bus.rd_data), 0);
        do_lock(16, 0, 1, 21, busy_n);
        bus.rd_row = 5'd21;
        #1;
        check("rd_before_edge", 32'(bus.rd_data), 0);
        sb_push("rd_row21_after_lock", 32'(mb[21]));
        tick();
        sb_pop(32'(bus.rd_data));
        check("rd_row21_const", 32'(bus.rd_data), 32'h00F);

        check("sb_drain", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
